// File: rtl/parity_frame_receiver.sv
// Deserialises strobed start/data/parity/stop frames, checks parity, presents word on valid/ready.
// Latency: out_valid rises the cycle after the stop-bit strobe; a good frame arriving while the output is held is dropped with an overrun pulse.
module parity_frame_receiver #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] data_out,
    output logic              par_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              acc;
    logic              perr_q;

    logic start_frm;
    logic shift_bit;
    logic latch_par;
    logic load_word;
    logic drop_word;
    logic bad_stop;

    // New bit enters at the MSB so the first-received bit lands in bit 0.
    assign shreg_nxt = DATA_W'({ser_in, shreg} >> 1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bit_en) begin
            case (state)
                IDLE:    if (!ser_in) state_nxt = DATA;
                DATA:    if (cnt == LAST) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        start_frm = 1'b0;
        shift_bit = 1'b0;
        latch_par = 1'b0;
        load_word = 1'b0;
        drop_word = 1'b0;
        bad_stop  = 1'b0;
        if (bit_en) begin
            case (state)
                IDLE:   start_frm = !ser_in;
                DATA:   shift_bit = 1'b1;
                PARITY: latch_par = 1'b1;
                STOP: begin
                    // The output register counts as free if it is being drained this very cycle.
                    if (!ser_in)                       bad_stop  = 1'b1;
                    else if (!out_valid || out_ready)  load_word = 1'b1;
                    else                               drop_word = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            shreg     <= '0;
            acc       <= 1'b0;
            perr_q    <= 1'b0;
            data_out  <= '0;
            par_err   <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= drop_word;
            if (start_frm) begin
                cnt <= '0;
                acc <= 1'b0;
            end
            if (shift_bit) begin
                shreg <= shreg_nxt;
                acc   <= acc ^ ser_in;
                cnt   <= cnt + 1'b1;
            end
            if (latch_par) perr_q <= acc ^ ser_in ^ PARITY_ODD;
            if (load_word) begin
                data_out  <= shreg;
                par_err   <= perr_q;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench for parity_frame_receiver: an even-parity instance plus an odd-parity instance fed the same line.
module tb_parity_frame_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_en;
    logic       ser_in;
    logic       out_ready;
    logic [7:0] data_out;
    logic       par_err;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;

    logic [7:0] odd_data;
    logic       odd_par_err;
    logic       odd_valid;
    logic       odd_frame_err;
    logic       odd_overrun;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    always #5 clk = ~clk;

    parity_frame_receiver #(.DATA_W(8), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .ser_in(ser_in),
        .data_out(data_out), .par_err(par_err), .out_valid(out_valid),
        .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun)
    );

    parity_frame_receiver #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .bit_en(bit_en), .ser_in(ser_in),
        .data_out(odd_data), .par_err(odd_par_err), .out_valid(odd_valid),
        .out_ready(1'b1), .frame_err(odd_frame_err), .overrun(odd_overrun)
    );

    always @(posedge clk) if (out_valid && out_ready) xfers <= xfers + 1;

    // One strobe, preceded by gap non-strobe cycles during which the line toggles.
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            bit_en = 1'b0;
            ser_in = ~ser_in;
            @(posedge clk); #1;
        end
        bit_en = 1'b1;
        ser_in = b;
        @(posedge clk); #1;
        bit_en = 1'b0;
        ser_in = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] d, input logic p, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
        send_head(d, p, gap);
        send_bit(s, gap);
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_en = 1'b0; ser_in = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({data_out, par_err, out_valid, frame_err, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 000", {data_out, par_err, out_valid, frame_err, overrun});
        end
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        out_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL good_word got v=%b d=%h exp v=1 d=a5", out_valid, data_out);
        end
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL good_par_err got %b exp 0", par_err);
        end
        checks++;
        if (odd_par_err !== 1'b1) begin
            errors++;
            $display("FAIL good_odd_par_err got %b exp 1", odd_par_err);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL good_valid_one_cycle got %b exp 0", out_valid);
        end
    endtask

    task automatic test_parity_error();
        out_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hA5 || par_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_even got v=%b d=%h pe=%b exp v=1 d=a5 pe=1", out_valid, data_out, par_err);
        end
        checks++;
        if (odd_valid !== 1'b1 || odd_data !== 8'hA5 || odd_par_err !== 1'b0) begin
            errors++;
            $display("FAIL perr_odd got v=%b d=%h pe=%b exp v=1 d=a5 pe=0", odd_valid, odd_data, odd_par_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_frame_error();
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        checks++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ferr_pulse got fe=%b v=%b exp fe=1 v=0", frame_err, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ferr_after got fe=%b v=%b exp fe=0 v=0", frame_err, out_valid);
        end
        send_frame(8'h11, 1'b0, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h11 || par_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_next got v=%b d=%h pe=%b exp v=1 d=11 pe=0", out_valid, data_out, par_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n0;
        out_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h5A) begin
            errors++;
            $display("FAIL bp_first got v=%b d=%h exp v=1 d=5a", out_valid, data_out);
        end
        send_frame(8'hC3, 1'b0, 1'b1, 0);
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || data_out !== 8'h5A) begin
            errors++;
            $display("FAIL bp_overrun got ov=%b v=%b d=%h exp ov=1 v=1 d=5a", overrun, out_valid, data_out);
        end
        @(posedge clk); #1;
        checks++;
        if (overrun !== 1'b0 || out_valid !== 1'b1 || data_out !== 8'h5A) begin
            errors++;
            $display("FAIL bp_hold got ov=%b v=%b d=%h exp ov=0 v=1 d=5a", overrun, out_valid, data_out);
        end
        n0 = xfers;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || xfers - n0 !== 1) begin
            errors++;
            $display("FAIL bp_release got v=%b xfers=%0d exp v=0 xfers=1", out_valid, xfers - n0);
        end
        // Drain and reload on the same stop strobe.
        out_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        send_head(8'hC3, 1'b0, 0);
        n0 = xfers;
        out_ready = 1'b1;
        send_bit(1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hC3 || overrun !== 1'b0 || xfers - n0 !== 1) begin
            errors++;
            $display("FAIL bp_replace got v=%b d=%h ov=%b xfers=%0d exp v=1 d=c3 ov=0 xfers=1",
                     out_valid, data_out, overrun, xfers - n0);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_replace_drain got %b exp 0", out_valid);
        end
    endtask

    task automatic test_sparse();
        out_ready = 1'b1;
        send_frame(8'h96, 1'b0, 1'b1, 3);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h96 || par_err !== 1'b0) begin
            errors++;
            $display("FAIL sparse got v=%b d=%h pe=%b exp v=1 d=96 pe=0", out_valid, data_out, par_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        out_ready = 1'b1;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n0 = xfers;
        send_frame(8'h7E, 1'b0, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h7E || par_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_word got v=%b d=%h pe=%b exp v=1 d=7e pe=0", out_valid, data_out, par_err);
        end
        @(posedge clk); #1;
        checks++;
        if (xfers - n0 !== 1) begin
            errors++;
            $display("FAIL rst_mid_count got %0d exp 1", xfers - n0);
        end
    endtask

    task automatic test_reset_pending();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pend_setup got %b exp 1", out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_pend got v=%b d=%h exp v=0 d=00", out_valid, data_out);
        end
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_frame_error();
        test_back_to_back();
        test_sparse();
        test_reset_mid_frame();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
